pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 32-bit RISC-V 5-stage core.
- Owns stall, bubble and flush control for the IF/ID/EX boundary.
- Arbitrates the single shared register-file port between WB writes and ID operand reads; that port carries one access per cycle, selected by op_write.
- Sits beside the ID stage and drives the enables of the IF/ID and ID/EX pipeline registers and the PC mux.

Parameters:
- REG_ADDR_W, 5, register address width.
- FLUSH_CYCLES, 2, bubbles inserted after a taken jump/branch (range 1..7).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- wb_write_req  in  1  WB requests the register-file port this cycle.
- control_j  in  1  ID resolved a taken jump/branch.
- pc_write  out  1  PC register enable.
- pc_sel  out  1  1 selects pc_j, 0 selects pc+4.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  force ID/EX control bits to 0.
- op_write  out  1  register-file port grant: 1 = WB write, 0 = ID read.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Encoding: INIT=0, RUN=1, STALL=2, FLUSH=3.
- Reset asserted: state=INIT, flush_cnt=0. Outputs: pc_write=0, pc_sel=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, op_write=0.
- INIT: outputs as in reset for exactly one clk after reset deasserts, then go to RUN.
- Hazard terms (combinational):
  - lu = id_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc = id_valid & wb_write_req & (id_use_rs1 | id_use_rs2).
- op_write = wb_write_req in every state except INIT. WB always wins the port.
- RUN, priority control_j > lu > pc:
  - control_j: pc_write=1, pc_sel=1, if_id_flush=1, id_ex_bubble=1, if_id_write=0. flush_cnt<=FLUSH_CYCLES-1. Next state FLUSH, or RUN if FLUSH_CYCLES==1.
  - lu or pc: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. Next state STALL.
  - none: pc_write=1, if_id_write=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0.
- STALL: one-cycle retry state.
  - Re-evaluate lu/pc with RUN rules.
  - A stall lasts while the hazard persists. A back-to-back WB write stalls again.
  - control_j is ignored in STALL. ID contents are frozen, so it re-asserts in RUN.
  - Hazard gone: RUN outputs for "none"; next state RUN.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1, pc_sel=0, if_id_write=0.
  - flush_cnt decrements each cycle; at 0 go to RUN.
  - lu/pc/control_j are ignored during FLUSH, since ID holds flushed NOPs.
- ex_rd==0 never causes a stall.
- Reset mid-STALL or mid-FLUSH: immediate return to INIT values; no pending flush survives.
- flush_cnt width: 3 bits.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt, flush_cnt_total, port_conflict_cnt (CNT_W each).
  - Each counts cycles spent in STALL, cycles in FLUSH, and stalls caused only by pc.
  - Counters are cleared by reset and saturate at all-ones (no wrap).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding constants, REG_ADDR_W, opcode localparams (R_TYPE_OP, LD_OP, JALR_OP, SB_TYPE_OP, UJ_TYPE_OP), and the NOP instruction constant 32'h00000013.
- Natural sub-module: hazard_detect, purely combinational; produces lu and pc from register fields.
- The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Reset release: after reset falls, one cycle with if_id_flush=1 and id_ex_bubble=1, then state_o=1 and pc_write=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle pc_write=0, id_ex_bubble=1. Next cycle ex_mem_read=0 → RUN, pc_write=1.
- Load to x0: ex_mem_read=1, ex_rd=0, id_rs1=0 → no stall; pc_write stays 1.
- Port conflict: wb_write_req=1 for 2 consecutive cycles with id_use_rs2=1 → op_write=1 and pc_write=0 both cycles; resumes the cycle after wb_write_req falls.
- Taken branch: control_j=1 in RUN → pc_sel=1 for one cycle, then if_id_flush=1 for FLUSH_CYCLES total cycles (2), then RUN. A control_j pulse during FLUSH is ignored.
- Priority and reset: control_j=1 with lu=1 simultaneously → flush path taken, no STALL. Assert reset during FLUSH → outputs at reset values asynchronously; state_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, register width, opcodes and the canonical NOP.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [6:0] R_TYPE_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP      = 7'b0000011;
  localparam logic [6:0] JALR_OP    = 7'b1100111;
  localparam logic [6:0] SB_TYPE_OP = 7'b1100011;
  localparam logic [6:0] UJ_TYPE_OP = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms for the ID stage:
// load-use (lu) and register-file port conflict (pc).
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_mem_read,
  input  logic          wb_write_req,
  output logic          lu,
  output logic          pc
);

  logic hit1;
  logic hit2;

  assign hit1 = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 & (id_rs2 == ex_rd);

  // x0 is hardwired, so a load into it never creates a dependency
  assign lu = id_valid & ex_mem_read & (ex_rd != '0)
            & (hit1 | hit2);

  assign pc = id_valid & wb_write_req
            & (id_use_rs1 | id_use_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencer and register-file port arbiter.
// PIPE_HAZARD_PERF_CNT_EN adds saturating performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  wb_write_req,
  input  logic                  control_j,
  output logic                  pc_write,
  output logic                  pc_sel,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  op_write,
  output logic [1:0]            state_o
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt_total,
  output logic [CNT_W-1:0]      port_conflict_cnt
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       lu, pc, hz;

  hazard_detect #(.AW(REG_ADDR_W)) u_hd (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .wb_write_req (wb_write_req),
    .lu           (lu),
    .pc           (pc)
  );

  assign hz       = lu | pc;
  assign op_write = (state_q != INIT) & wb_write_req;
  assign state_o  = state_q;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state_q)
      INIT: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN, STALL: begin
        // ID is frozen in STALL, so a jump there re-asserts once in RUN
        if (control_j && state_q == RUN) begin
          pc_write     = 1'b1;
          pc_sel       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_cnt_d  = FLUSH_INIT;
          state_d      = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (hz) begin
          id_ex_bubble = 1'b1;
          state_d      = STALL;
        end else begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          state_d      = RUN;
        end
      end
      FLUSH: begin
        pc_write     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_cnt_d  = (flush_cnt_q == 3'd0) ? 3'd0
                     : flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_tot_q, conflict_q;
  logic             pc_only;

  assign pc_only = pc & ~lu & (state_q == STALL
                 | (state_q == RUN & ~control_j));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_tot_q <= '0;
      conflict_q  <= '0;
    end else begin
      if (state_q == STALL && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_q == FLUSH && !(&flush_tot_q))
        flush_tot_q <= flush_tot_q + CNT_W'(1);
      if (pc_only && !(&conflict_q))
        conflict_q <= conflict_q + CNT_W'(1);
    end
  end

  assign stall_cnt         = stall_cnt_q;
  assign flush_cnt_total   = flush_tot_q;
  assign port_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, wb_write_req, control_j;
  logic       pc_write, pc_sel, if_id_write, if_id_flush;
  logic       id_ex_bubble, op_write;
  logic [1:0] state_o;
  logic [7:0] obs;
  logic [7:0] e;

  int total = 0;
  int bad   = 0;

  // model state: pending INIT cycle, bubbles still owed, retry cycle
  bit m_init;
  int m_left;
  bit m_stall;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .wb_write_req (wb_write_req),
    .control_j    (control_j),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .op_write     (op_write),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_sel, if_id_write, if_id_flush,
                id_ex_bubble, op_write, state_o};

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; wb_write_req = 0; control_j = 0;
  endtask

  // {pc_write,pc_sel,if_id_write,if_id_flush,bubble,op_write,state}
  task automatic model(output logic [7:0] ex);
    bit lu, pcc, j;
    logic [1:0] st;
    lu = id_valid && ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) ||
          (id_use_rs2 && id_rs2 == ex_rd));
    pcc = id_valid && wb_write_req && (id_use_rs1 || id_use_rs2);
    if (m_init) begin
      ex = {5'b00011, 1'b0, 2'd0};
      m_init = 0; m_stall = 0;
    end else if (m_left > 0) begin
      ex = {5'b10011, wb_write_req, 2'd3};
      m_left--;
    end else begin
      st = m_stall ? 2'd2 : 2'd1;
      j  = control_j && !m_stall;
      if (j) begin
        ex = {5'b11011, wb_write_req, st};
        m_left = FC - 1; m_stall = 0;
      end else if (lu || pcc) begin
        ex = {5'b00001, wb_write_req, st};
        m_stall = 1;
      end else begin
        ex = {5'b10100, wb_write_req, st};
        m_stall = 0;
      end
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    idle();
    #1;
    total++;
    if (obs !== 8'b00011_0_00) begin
      bad++;
      $display("FAIL %s_async: got %b want %b", tag, obs, 8'b00011000);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_init = 1; m_left = 0; m_stall = 0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    #1; model(e);
    total++;
    if (obs !== e || if_id_flush !== 1 || id_ex_bubble !== 1) begin
      bad++; $display("FAIL reset_init: got %b want %b", obs, e);
    end
    @(negedge clk);
    #1; model(e);
    total++;
    if (obs !== e || state_o !== 2'd1 || pc_write !== 1) begin
      bad++; $display("FAIL reset_run: got %b want %b", obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    id_valid = 1; ex_mem_read = 1; ex_rd = 5;
    id_rs1 = 5; id_use_rs1 = 1;
    #1; model(e);
    total++;
    if (obs !== e || pc_write !== 0 || id_ex_bubble !== 1) begin
      bad++; $display("FAIL load_use_stall: got %b want %b", obs, e);
    end
    @(negedge clk);
    ex_mem_read = 0;
    #1; model(e);
    total++;
    if (obs !== e || pc_write !== 1) begin
      bad++; $display("FAIL load_use_clear: got %b want %b", obs, e);
    end
    @(negedge clk);
    idle();
    #1; model(e);
    total++;
    if (obs !== e || state_o !== 2'd1) begin
      bad++; $display("FAIL load_use_run: got %b want %b", obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_load_x0();
    id_valid = 1; ex_mem_read = 1; ex_rd = 0;
    id_rs1 = 0; id_use_rs1 = 1;
    for (int i = 0; i < 2; i++) begin
      #1; model(e);
      total++;
      if (obs !== e || pc_write !== 1) begin
        bad++; $display("FAIL load_x0_%0d: got %b want %b", i, obs, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_port_conflict();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 7; wb_write_req = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wb_write_req = 0;
      #1; model(e);
      total++;
      if (obs !== e || pc_write !== (i == 2) || op_write !== (i < 2)) begin
        bad++; $display("FAIL port_conflict_%0d: got %b want %b", i, obs, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_branch();
    control_j = 1;
    for (int i = 0; i < FC + 1; i++) begin
      if (i == 1) control_j = 1;
      if (i == 0 || i == FC) control_j = (i == 0);
      #1; model(e);
      total++;
      if (obs !== e || if_id_flush !== (i < FC) || pc_sel !== (i == 0)) begin
        bad++; $display("FAIL branch_%0d: got %b want %b", i, obs, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_priority_reset();
    control_j = 1; id_valid = 1; ex_mem_read = 1;
    ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    #1; model(e);
    total++;
    if (obs !== e || pc_sel !== 1 || pc_write !== 1) begin
      bad++; $display("FAIL prio_jump: got %b want %b", obs, e);
    end
    @(negedge clk);
    idle();
    #1; model(e);
    total++;
    if (obs !== e || state_o !== 2'd3) begin
      bad++; $display("FAIL prio_flush: got %b want %b", obs, e);
    end
    #2;
    apply_reset("flush_reset");
    #1; model(e);
    total++;
    if (obs !== e || state_o !== 2'd0) begin
      bad++; $display("FAIL flush_reset_init: got %b want %b", obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        apply_reset("rand_reset");
        continue;
      end
      id_valid     = ($urandom_range(0, 5) != 0);
      id_use_rs1   = $urandom_range(0, 1);
      id_use_rs2   = $urandom_range(0, 1);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      wb_write_req = ($urandom_range(0, 3) == 0);
      control_j    = ($urandom_range(0, 5) == 0);
      #1; model(e);
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL random_%0d: got %b want %b", i, obs, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_load_x0();
    test_port_conflict();
    test_branch();
    test_priority_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
